serial_byte_receiver: RTL



---
 rtl/serial_rx_pkg.sv | 18 +
 rtl/sync_2ff.sv | 26 ++
 rtl/serial_byte_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and sizing helpers for the serial byte receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int BITS_PER_BYTE = 8;

  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer; RST_VAL sets the value both stages reset to.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// Serial RX front end: start/stop framing, LSB-first assembly, one-entry
// valid/ready holding register with framing-error and overrun pulses.
//
//   state | meaning
//   IDLE  | line idle, waiting for a low level (start edge)
//   START | timing to mid start bit to reject glitches
//   DATA  | sampling 8 data bits at mid-bit
//   STOP  | sampling stop bit; deliver byte or flag framing error
//   BREAK | line stuck low after a bad stop; wait for it to go high
module serial_byte_receiver
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       RX,
  output logic [7:0] BYTE_OUT,
  output logic       BYTE_VALID,
  input  logic       BYTE_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_BYTE - 1);

  logic rx_s;

  rx_state_t                state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [BITS_PER_BYTE-1:0] sr_q, sr_d;
  logic [BITS_PER_BYTE-1:0] byte_q, byte_d;
  logic                     valid_q, valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic                     deliver;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk   (CLK),
    .rst_n (nRST),
    .d     (RX),
    .q     (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    sr_d        = sr_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          sr_d  = {rx_s, sr_q[BITS_PER_BYTE-1:1]};
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        // No start detection here: the line must return high first.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_d    = byte_q;
    valid_d   = valid_q & ~BYTE_READY;
    overrun_d = 1'b0;
    if (deliver) begin
      // Same-cycle accept frees the slot, so the new byte may load.
      if (!valid_q || BYTE_READY) begin
        byte_d  = sr_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      sr_q        <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      sr_q        <= sr_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign BYTE_OUT   = byte_q;
  assign BYTE_VALID = valid_q;
  assign FRAME_ERR  = frame_err_q;
  assign OVERRUN    = overrun_q;

endmodule
